// File: rtl/aes_pkg.sv
// Shared AES definitions: round-state encoding, rcon table and S-box.
// The round datapath imports this package too, so both sides use one state encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ROUND0    = 2'd1,
    ROUND1TO9 = 2'd2,
    ROUND10   = 2'd3
  } round_state_t;

  // Forward S-box. Byte 0x00 is stored in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant for key-schedule round 1..10; other indices are never used.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes128_key_expand.sv
// Combinational AES-128 key-schedule step: previous round key + rcon -> next round key.
module aes128_key_expand
  import aes_pkg::*;
(
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  input  logic [7:0]  rcon_byte,
  output logic [31:0] n0,
  output logic [31:0] n1,
  output logic [31:0] n2,
  output logic [31:0] n3
);

  logic [31:0] rot;
  logic [31:0] t;

  assign rot = {k3[23:0], k3[31:24]};
  assign t   = sub_word(rot) ^ {rcon_byte, 24'h0};

  assign n0 = k0 ^ t;
  assign n1 = k1 ^ n0;
  assign n2 = k2 ^ n1;
  assign n3 = k3 ^ n2;

endmodule

// File: rtl/aes128_round_ctrl.sv
// AES-128 round sequencer with on-the-fly key expansion, one round key per cycle.
// Optional AES_ROUND_CTRL_ABORT_EN adds abort_in to cancel a running encryption.
module aes128_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int WW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start_in,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic          abort_in,
`endif
  input  logic [WW-1:0] key0_in,
  input  logic [WW-1:0] key1_in,
  input  logic [WW-1:0] key2_in,
  input  logic [WW-1:0] key3_in,
  output logic [1:0]    state_out,
  output logic [WW-1:0] rkey0_out,
  output logic [WW-1:0] rkey1_out,
  output logic [WW-1:0] rkey2_out,
  output logic [WW-1:0] rkey3_out,
  output logic          ready_out,
  output logic          done_out
);

  if (NR != 10) begin : g_bad_nr
    $error("aes128_round_ctrl: NR must be 10 for AES-128");
  end
  if (WW != 32) begin : g_bad_ww
    $error("aes128_round_ctrl: WW must be 32");
  end

  round_state_t         state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [3:0][WW-1:0]   rk, rk_nxt;
  logic [3:0][WW-1:0]   rk_exp;
  logic                 done, done_nxt;
  logic                 abort;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort = abort_in;
`else
  assign abort = 1'b0;
`endif

  // The key for round cnt+1 is derived from the key currently on the outputs.
  aes128_key_expand u_key_expand (
    .k0        (rk[0]),
    .k1        (rk[1]),
    .k2        (rk[2]),
    .k3        (rk[3]),
    .rcon_byte (rcon(cnt + 4'd1)),
    .n0        (rk_exp[0]),
    .n1        (rk_exp[1]),
    .n2        (rk_exp[2]),
    .n3        (rk_exp[3])
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rk_nxt    = rk;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_nxt = ROUND0;
          cnt_nxt   = 4'd0;
          rk_nxt    = {key3_in, key2_in, key1_in, key0_in};
        end
      end
      ROUND0: begin
        state_nxt = ROUND1TO9;
        cnt_nxt   = 4'd1;
        rk_nxt    = rk_exp;
      end
      ROUND1TO9: begin
        cnt_nxt = cnt + 4'd1;
        rk_nxt  = rk_exp;
        if (cnt == 4'(NR - 1)) state_nxt = ROUND10;
      end
      ROUND10: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        rk_nxt    = '0;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        rk_nxt    = '0;
      end
    endcase
    // Abort wins over the normal sequence but never cancels a start from IDLE.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
      rk_nxt    = '0;
      done_nxt  = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the round-key registers are reset too, because they drive visible outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rk    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rk    <= rk_nxt;
      done  <= done_nxt;
    end
  end

  assign state_out = state;
  assign rkey0_out = rk[0];
  assign rkey1_out = rk[1];
  assign rkey2_out = rk[2];
  assign rkey3_out = rk[3];
  assign ready_out = (state == IDLE);
  assign done_out  = done;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: vector table + scoreboard, FIPS-197 key schedule.
// Build with AES_ROUND_CTRL_ABORT_EN defined to also exercise abort_in.
module tb_aes128_round_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] key0, key1, key2, key3;
  logic [1:0]  state_out;
  logic [31:0] rkey0, rkey1, rkey2, rkey3;
  logic        ready, done;

  always #5 clk = ~clk;

  aes128_round_ctrl dut (
    .CLK       (clk),
    .RST       (rst),
    .start_in  (start),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort_in  (abort),
`endif
    .key0_in   (key0),
    .key1_in   (key1),
    .key2_in   (key2),
    .key3_in   (key3),
    .state_out (state_out),
    .rkey0_out (rkey0),
    .rkey1_out (rkey1),
    .rkey2_out (rkey2),
    .rkey3_out (rkey3),
    .ready_out (ready),
    .done_out  (done)
  );

  // Inputs applied before an edge, and the outputs required right after it.
  typedef struct {
    logic         start;
    logic         rst;
    logic         abort;
    logic [127:0] key;
    logic [1:0]   st;
    logic [127:0] rk;
    logic         chk_rk;
    logic         rdy;
    logic         dn;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  vec_t         vecs[$];
  vec_t         sb_q[$];
  logic [127:0] rk_tbl [2][11];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string name, input int idx, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic a, input logic [127:0] k,
                     input logic [1:0] st, input logic [127:0] rk, input logic chk,
                     input logic rdy, input logic dn);
    vec_t v;
    v.start = s; v.rst = r; v.abort = a; v.key = k;
    v.st = st; v.rk = rk; v.chk_rk = chk; v.rdy = rdy; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input logic s, input logic r, input logic a, input logic [127:0] k,
                          input logic dn);
    add(s, r, a, k, 2'd0, 128'h0, 1'b1, 1'b1, dn);
  endtask

  // n edges of an encryption accepted on the first one; keys switch to 'later' from edge 3.
  task automatic add_enc(input logic [127:0] key, input int sel, input logic hold,
                         input logic abort0, input logic [127:0] later, input int n);
    logic [1:0]   st;
    logic         chk;
    logic [127:0] kin;
    for (int k = 0; k < n; k++) begin
      st  = (k == 0) ? 2'd1 : ((k == 10) ? 2'd3 : 2'd2);
      chk = (sel == 0) || (k <= 3) || (k == 10);
      kin = (k >= 3) ? later : key;
      add((k == 0) ? 1'b1 : hold, 1'b0, (k == 0) ? abort0 : 1'b0, kin, st,
          rk_tbl[sel][k], chk, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t e;
    int   cyc;

    // FIPS-197 appendix A.1 expansion.
    rk_tbl[0][0]  = FIPS_KEY;
    rk_tbl[0][1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    rk_tbl[0][2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    rk_tbl[0][3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    rk_tbl[0][4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    rk_tbl[0][5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    rk_tbl[0][6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    rk_tbl[0][7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    rk_tbl[0][8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    rk_tbl[0][9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    rk_tbl[0][10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    // All-zero key: rounds 0..3 and 10 are compared, the rest only by state.
    for (int k = 0; k < 11; k++) rk_tbl[1][k] = 128'h0;
    rk_tbl[1][1]  = 128'h62636363_62636363_62636363_62636363;
    rk_tbl[1][2]  = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;
    rk_tbl[1][3]  = 128'h90973450_696ccffa_f2f45733_0b0fac99;
    rk_tbl[1][10] = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    // Reset held 3 cycles with start asserted: reset has priority.
    repeat (3) add_idle(1'b1, 1'b1, 1'b0, FIPS_KEY, 1'b0);
    add_idle(1'b0, 1'b0, 1'b0, FIPS_KEY, 1'b0);
    // Single FIPS encryption; key inputs change at T+3 without effect.
    add_enc(FIPS_KEY, 0, 1'b0, 1'b0, ZERO_KEY, 11);
    add_idle(1'b0, 1'b0, 1'b0, ZERO_KEY, 1'b1);
    add_idle(1'b0, 1'b0, 1'b0, ZERO_KEY, 1'b0);
    // start held high: back-to-back runs, second one picks up the new key at T+12.
    add_enc(FIPS_KEY, 0, 1'b1, 1'b0, ZERO_KEY, 11);
    add_idle(1'b1, 1'b0, 1'b0, ZERO_KEY, 1'b1);
    add_enc(ZERO_KEY, 1, 1'b1, 1'b0, ZERO_KEY, 11);
    add_idle(1'b1, 1'b0, 1'b0, ZERO_KEY, 1'b1);
    add_idle(1'b0, 1'b0, 1'b0, ZERO_KEY, 1'b0);
    // Reset at T+6: idle at T+7, no done at T+12, then a clean run.
    add_enc(FIPS_KEY, 0, 1'b0, 1'b0, FIPS_KEY, 6);
    add_idle(1'b0, 1'b1, 1'b0, FIPS_KEY, 1'b0);
    repeat (6) add_idle(1'b0, 1'b0, 1'b0, FIPS_KEY, 1'b0);
    add_enc(ZERO_KEY, 1, 1'b0, 1'b0, ZERO_KEY, 11);
    add_idle(1'b0, 1'b0, 1'b0, ZERO_KEY, 1'b1);
    add_idle(1'b0, 1'b0, 1'b0, ZERO_KEY, 1'b0);
`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort at T+4 -> idle at T+5; start together with abort in IDLE is accepted.
    add_enc(FIPS_KEY, 0, 1'b0, 1'b0, FIPS_KEY, 4);
    add_idle(1'b0, 1'b0, 1'b1, FIPS_KEY, 1'b0);
    add_enc(FIPS_KEY, 0, 1'b0, 1'b1, FIPS_KEY, 11);
    add_idle(1'b0, 1'b0, 1'b0, FIPS_KEY, 1'b1);
    add_idle(1'b0, 1'b0, 1'b1, FIPS_KEY, 1'b0);
    add_idle(1'b0, 1'b0, 1'b0, FIPS_KEY, 1'b0);
`endif

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    {key0, key1, key2, key3} = FIPS_KEY;

    foreach (vecs[i]) begin
      v = vecs[i];
      rst = v.rst; start = v.start; abort = v.abort;
      {key0, key1, key2, key3} = v.key;
      sb_q.push_back(v);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      check("state", i, 128'(state_out), 128'(e.st));
      check("ready", i, 128'(ready), 128'(e.rdy));
      check("done", i, 128'(done), 128'(e.dn));
      if (e.chk_rk) check("rkey", i, {rkey0, rkey1, rkey2, rkey3}, e.rk);
    end

    // A start pulse while busy is dropped, not queued behind the running encryption.
    rst = 1'b0; abort = 1'b0;
    {key0, key1, key2, key3} = FIPS_KEY;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 6;
    while (!done && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_done_seen", 0, 128'(done), 128'(1));
    check("busy_done_cycle", 0, 128'(cyc), 128'(12));
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      check("busy_not_queued", j, 128'(state_out), 128'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
